// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the RV32I cores: opcodes, FSM states, mux selects.
package rv_ctrl_pkg;

    localparam int unsigned OP_W = 7;
    localparam int unsigned ST_W = 4;

    // Opcodes (IR[6:0])
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_B   = 7'b1100011;
    localparam logic [OP_W-1:0] OP_LUI = 7'b0110111;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    typedef enum logic [ST_W-1:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRead = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StExecI   = 4'd7,
        StJal     = 4'd8,
        StAluWb   = 4'd9,
        StBeq     = 4'd10,
        StLui     = 4'd11
    } state_e;

    // result_src
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    // alu_src_a
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // alu_src_b
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // alu_op
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // imm_src
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: status inputs to the FSM and all control strobes/selects.
interface multicycle_controller_if;
    import rv_ctrl_pkg::*;

    logic [OP_W-1:0] op;
    logic            zero;
    logic            mem_ready;
    logic            pc_write;
    logic            adr_src;
    logic            mem_write;
    logic            ir_write;
    logic [1:0]      result_src;
    logic [1:0]      alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic [2:0]      imm_src;
    logic            reg_write;
    logic            instr_done;
    logic            illegal_op;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               alu_op, imm_src, reg_write, instr_done, illegal_op
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               alu_op, imm_src, reg_write, instr_done, illegal_op
    );

endinterface

// File: rtl/imm_src_decode.sv
// Opcode -> immediate format select; purely combinational, shared with the single-cycle core.
module imm_src_decode
    import rv_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output logic [2:0]      imm_src_o
);

    // Loads, I-type and anything unknown use the I format
    always_comb begin
        imm_src_o = IMM_I;
        case (op_i)
            OP_SW:   imm_src_o = IMM_S;
            OP_B:    imm_src_o = IMM_B;
            OP_JAL:  imm_src_o = IMM_J;
            OP_LUI:  imm_src_o = IMM_U;
            default: imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core (Moore decode, mem_ready/zero-gated PC/IR).
module multicycle_controller
    import rv_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);

    state_e     state_q, state_d;
    logic       pc_we, ir_we, mem_we, reg_we, done, illegal;
    logic       adr_sel;
    logic [1:0] res_sel, srca_sel, srcb_sel, aluop_sel;

    // State register, asynchronous return to FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d   = StFetch;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        adr_sel   = 1'b0;
        res_sel   = RES_ALUOUT;
        srca_sel  = SRCA_PC;
        srcb_sel  = SRCB_RS2;
        aluop_sel = ALU_ADD;
        case (state_q)
            StFetch: begin
                srcb_sel = SRCB_FOUR;
                res_sel  = RES_ALURESULT;
                ir_we    = bus.mem_ready;
                pc_we    = bus.mem_ready;
                state_d  = bus.mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                // ALUOut captures OldPC + imm as the branch/jump target
                srca_sel = SRCA_OLDPC;
                srcb_sel = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_R:         state_d = StExecR;
                    OP_I:         state_d = StExecI;
                    OP_B:         state_d = StBeq;
                    OP_JAL:       state_d = StJal;
                    OP_LUI:       state_d = StLui;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                srca_sel = SRCA_RS1;
                srcb_sel = SRCB_IMM;
                state_d  = (bus.op == OP_SW) ? StMemWr : StMemRead;
            end
            StMemRead: begin
                adr_sel = 1'b1;
                state_d = bus.mem_ready ? StMemWb : StMemRead;
            end
            StMemWb: begin
                res_sel = RES_DATA;
                reg_we  = 1'b1;
                done    = 1'b1;
            end
            StMemWr: begin
                adr_sel = 1'b1;
                mem_we  = 1'b1;
                done    = bus.mem_ready;
                state_d = bus.mem_ready ? StFetch : StMemWr;
            end
            StExecR: begin
                srca_sel  = SRCA_RS1;
                aluop_sel = ALU_FUNCT;
                state_d   = StAluWb;
            end
            StExecI: begin
                srca_sel  = SRCA_RS1;
                srcb_sel  = SRCB_IMM;
                aluop_sel = ALU_FUNCT;
                state_d   = StAluWb;
            end
            StJal: begin
                // PC <- target held in ALUOut; ALU forms OldPC + 4 for the link
                srca_sel = SRCA_OLDPC;
                srcb_sel = SRCB_FOUR;
                pc_we    = 1'b1;
                state_d  = StAluWb;
            end
            StAluWb: begin
                reg_we = 1'b1;
                done   = 1'b1;
            end
            StBeq: begin
                srca_sel  = SRCA_RS1;
                aluop_sel = ALU_SUB;
                pc_we     = bus.zero;
                done      = 1'b1;
            end
            StLui: begin
                res_sel = RES_IMMEXT;
                reg_we  = 1'b1;
                done    = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    // Enables are killed combinationally while reset is held
    assign bus.pc_write   = pc_we & rst_n;
    assign bus.ir_write   = ir_we & rst_n;
    assign bus.mem_write  = mem_we & rst_n;
    assign bus.reg_write  = reg_we & rst_n;
    assign bus.instr_done = done & rst_n;
    assign bus.illegal_op = illegal & rst_n;
    assign bus.adr_src    = adr_sel;
    assign bus.result_src = res_sel;
    assign bus.alu_src_a  = srca_sel;
    assign bus.alu_src_b  = srcb_sel;
    assign bus.alu_op     = aluop_sel;

    imm_src_decode u_imm_src_decode (
        .op_i      (bus.op),
        .imm_src_o (bus.imm_src)
    );

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core. It sequences one shared ALU, one unified instruction/data memory port, the IR, OldPC and ALUOut registers, and the register file across 3–5 cycles per instruction.
- Consumes the opcode from the IR, ALU Zero and a memory ready handshake. Drives all mux selects and write enables.
- Funct3/funct7 decode stays in the existing ALU decoder, fed by ALUOp.

Parameters:
- OP_W, 7, opcode width
- ST_W, 4, state register width (12 states used)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  IR[6:0]; stable from the cycle after IRWrite
- zero  in  1  ALU Zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  0 = PC, 1 = ALUOut to memory address
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR/OldPC load
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 ImmExt, 10 constant 4
- alu_op  out  2  00 add, 01 sub, 10 funct decode
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- reg_write  out  1  register-file write enable
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse on an unknown opcode in DECODE

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous, active-low.
  - rst_n low sets state to FETCH.
  - While rst_n is low, pc_write, mem_write, ir_write, reg_write, instr_done and illegal_op are forced to 0 combinationally. All other outputs take their FETCH values.
- Output style: Moore outputs decoded from state only. The exceptions are pc_write and ir_write, which are gated with mem_ready or zero as listed below. Any unlisted select is 0.
- imm_src is a pure function of op in every state: I/lw = 000, sw = 001, beq = 010, jal = 011, lui = 100, other = 000.
- States and outputs:
  - FETCH: adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10, ir_write=mem_ready, pc_write=mem_ready. Stay while !mem_ready; otherwise go to DECODE.
  - DECODE: src_a=01, src_b=01, alu_op=00 (ALUOut captures the branch/jump target). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - 0110111 -> LUI
    - otherwise -> FETCH with illegal_op=1 (no side effects).
  - MEMADR: src_a=10, src_b=01, alu_op=00. Next is MEMREAD if op=lw, MEMWR if op=sw.
  - MEMREAD: adr_src=1, result_src=00. Stay while !mem_ready; otherwise go to MEMWB.
  - MEMWB: result_src=01, reg_write=1, instr_done=1. Next is FETCH.
  - MEMWR: adr_src=1, result_src=00, mem_write=1, held high until mem_ready. instr_done=mem_ready. When ready, go to FETCH.
  - EXEC_R: src_a=10, src_b=00, alu_op=10. Next is ALUWB.
  - EXEC_I: src_a=10, src_b=01, alu_op=10. Next is ALUWB.
  - JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_write=1. Next is ALUWB.
  - ALUWB: result_src=00, reg_write=1, instr_done=1. Next is FETCH.
  - BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, pc_write=zero, instr_done=1. Next is FETCH.
  - LUI: result_src=11, reg_write=1, instr_done=1. Next is FETCH.
- Latency with zero-wait memory:
  - lw = 5 cycles
  - sw, R, I, jal = 4 cycles
  - beq, lui = 3 cycles
  - Each mem_ready-low cycle adds 1 in FETCH, MEMREAD or MEMWR.
- Boundary conditions:
  - Unused state encodings go to FETCH with all enables 0.
  - An op change outside DECODE/MEMADR has no effect on sequencing.
  - rst_n asserted mid-MEMWR drops mem_write immediately (asynchronous).
  - At most one of reg_write, mem_write, ir_write is high in any cycle.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode constants OP_R, OP_I, OP_LW, OP_SW, OP_B, OP_LUI, OP_JAL
  - state enum
  - result_src, alu_src_a, alu_src_b, alu_op and imm_src encodings, shared with the single-cycle decoder and the datapath.
- One natural sub-module: imm_src_decode (combinational op -> imm_src), reused by the single-cycle core.
- The FSM, next-state logic and output decode stay in multicycle_controller.

Test Plan:
- Reset:
  - Stimulus: rst_n low asynchronously mid-cycle while in MEMWR with mem_write=1.
  - Response: mem_write=0 within the same cycle; state FETCH after release; first cycle shows src_b=10, result_src=10.
- R-type add:
  - Stimulus: op=0110011, mem_ready=1.
  - Response: visits FETCH, DECODE, EXEC_R, ALUWB; reg_write=1 only in cycle 4; instr_done pulses once; alu_op=10 in cycle 3.
- lw with wait states:
  - Stimulus: op=0000011, mem_ready low 2 cycles in FETCH and 1 cycle in MEMREAD.
  - Response: 8 cycles total; ir_write and pc_write assert only on the ready FETCH cycle; reg_write with result_src=01 in the final cycle.
- beq:
  - Stimulus: op=1100011, zero=1, then a second run with zero=0.
  - Response: 3 cycles each; pc_write=1 in BEQ for the first run only; alu_op=01, imm_src=010.
- jal and lui:
  - Stimulus: op=1101111, then op=0110111.
  - Response (jal): pc_write in the JAL state, reg_write with result_src=00 in the next cycle, imm_src=011.
  - Response (lui): 3 cycles, result_src=11, imm_src=100.
- Illegal opcode:
  - Stimulus: op=1111111.
  - Response: illegal_op pulses in DECODE; no reg_write, mem_write or extra pc_write; next state FETCH.
